// File: rtl/eth_pdu_queue_if.sv
// Byte-stream write side and sender handshake of eth_pdu_queue.
// slave = the queue itself, master = the producer/sender environment.
interface eth_pdu_queue_if #(
  parameter int DESC_LOG2  = 2,
  parameter int CHAN_WIDTH = 2
);
  logic [7:0]            i_data;
  logic                  i_wr;
  logic                  i_din;
  logic [CHAN_WIDTH-1:0] i_chan;
  logic                  o_full;
  logic                  o_empty;
  logic [DESC_LOG2:0]    o_level;
  logic                  o_trig_send;
  logic [10:0]           o_pdu_len;
  logic [7:0]            o_pck_ident;
  logic [7:0]            o_pck_idx;
  logic [CHAN_WIDTH-1:0] o_pdu_chan;
  logic                  i_get_byte;
  logic [7:0]            o_byte;
  logic                  i_send_over;
  logic [15:0]           o_drop_cnt;

  modport slave (
    input  i_data, i_wr, i_din, i_chan, i_get_byte, i_send_over,
    output o_full, o_empty, o_level, o_trig_send, o_pdu_len, o_pck_ident,
           o_pck_idx, o_pdu_chan, o_byte, o_drop_cnt
  );

  modport master (
    output i_data, i_wr, i_din, i_chan, i_get_byte, i_send_over,
    input  o_full, o_empty, o_level, o_trig_send, o_pdu_len, o_pck_ident,
           o_pck_idx, o_pdu_chan, o_byte, o_drop_cnt
  );
endinterface

// File: rtl/eth_pdu_queue.sv
// PDU buffer: slices write bursts into PDUs, queues descriptors and feeds them to the sender.
// Optional EPQ_DROP_CNT_EN enables the saturating dropped-byte counter on o_drop_cnt.
module eth_pdu_queue #(
  parameter int PDU_SIZE   = 1470,
  parameter int ADDR_WIDTH = 13,
  parameter int DESC_LOG2  = 2,
  parameter int CHAN_WIDTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  eth_pdu_queue_if.slave bus
);
  localparam int NDESC     = 1 << DESC_LOG2;
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [10:0]           PDU_LEN  = 11'(PDU_SIZE);
  localparam logic [10:0]           PDU_LAST = 11'(PDU_SIZE - 1);
  localparam logic [DESC_LOG2:0]    LVL_FULL = (DESC_LOG2 + 1)'(NDESC);
  localparam logic [DESC_LOG2:0]    LVL_ONE  = 1;
  localparam logic [DESC_LOG2-1:0]  IDX_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, TRIG, SEND, DONE} rd_state_e;

  logic [7:0]            mem     [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] d_start [NDESC];
  logic [10:0]           d_len   [NDESC];
  logic [7:0]            d_ident [NDESC];
  logic [7:0]            d_idx   [NDESC];
  logic [CHAN_WIDTH-1:0] d_chan  [NDESC];

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, start_q, start_d, rd_addr_q, rd_addr_d;
  logic [10:0]           wr_size_q, wr_size_d, pdu_len_q, pdu_len_d;
  logic                  storing_q, storing_d, trig_q, trig_d;
  logic [CHAN_WIDTH-1:0] chan_q, chan_d, pdu_chan_q, pdu_chan_d;
  logic [7:0]            ident_q, ident_d, idx_q, idx_d;
  logic [7:0]            pck_ident_q, pck_ident_d, pck_idx_q, pck_idx_d, byte_q, byte_d;
  logic [DESC_LOG2-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [DESC_LOG2:0]    level_q, level_d;

  logic                  full, wren, commit, pop;
  logic [ADDR_WIDTH-1:0] c_start;
  logic [10:0]           c_len;
  logic [CHAN_WIDTH-1:0] c_chan;

  assign full = (level_q == LVL_FULL);
  assign wren = bus.i_wr & bus.i_din & ~full;

  // Write side: PDU slicing and descriptor commit
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_size_d = wr_size_q;
    storing_d = storing_q | bus.i_wr;
    start_d   = start_q;
    chan_d    = chan_q;
    ident_d   = ident_q;
    idx_d     = idx_q;
    commit    = 1'b0;
    c_start   = start_q;
    c_len     = wr_size_q;
    c_chan    = chan_q;
    if (wren) begin
      wr_addr_d = wr_addr_q + ADDR_ONE;
      if (wr_size_q == 11'd0) begin
        start_d = wr_addr_q;
        chan_d  = bus.i_chan;
        c_start = wr_addr_q;
        c_chan  = bus.i_chan;
      end
      if (wr_size_q == PDU_LAST) begin
        commit    = 1'b1;
        c_len     = PDU_LEN;
        wr_size_d = 11'd0;
        idx_d     = idx_q + 8'd1;
      end else begin
        wr_size_d = wr_size_q + 11'd1;
      end
    end else if (!bus.i_wr && storing_q) begin
      // An exact multiple of PDU_SIZE leaves nothing pending, so no empty PDU is queued
      commit    = (wr_size_q != 11'd0);
      ident_d   = ident_q + 8'd1;
      idx_d     = 8'd0;
      wr_size_d = 11'd0;
      storing_d = 1'b0;
    end
  end

  // Read FSM: present head descriptor, stream bytes, pop on send_over
  always_comb begin
    state_d     = state_q;
    trig_d      = 1'b0;
    pop         = 1'b0;
    rd_addr_d   = rd_addr_q;
    pdu_len_d   = pdu_len_q;
    pck_ident_d = pck_ident_q;
    pck_idx_d   = pck_idx_q;
    pdu_chan_d  = pdu_chan_q;
    unique case (state_q)
      IDLE: if (level_q != '0) state_d = TRIG;
      TRIG: begin
        pdu_len_d   = d_len[rd_idx_q];
        pck_ident_d = d_ident[rd_idx_q];
        pck_idx_d   = d_idx[rd_idx_q];
        pdu_chan_d  = d_chan[rd_idx_q];
        rd_addr_d   = d_start[rd_idx_q];
        trig_d      = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (bus.i_get_byte) rd_addr_d = rd_addr_q + ADDR_ONE;
        if (bus.i_send_over) begin
          pop     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reading at the next address makes the first byte valid alongside o_trig_send
    byte_d   = mem[rd_addr_d];
    wr_idx_d = commit ? wr_idx_q + IDX_ONE : wr_idx_q;
    rd_idx_d = pop ? rd_idx_q + IDX_ONE : rd_idx_q;
    unique case ({commit, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wren) mem[wr_addr_q] <= bus.i_data;
    if (commit) begin
      d_start[wr_idx_q] <= c_start;
      d_len[wr_idx_q]   <= c_len;
      d_ident[wr_idx_q] <= ident_q;
      d_idx[wr_idx_q]   <= idx_q;
      d_chan[wr_idx_q]  <= c_chan;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_addr_q <= '0; wr_size_q <= '0; storing_q <= 1'b0; start_q <= '0;
      chan_q <= '0; ident_q <= '0; idx_q <= '0; wr_idx_q <= '0; rd_idx_q <= '0;
      level_q <= '0; rd_addr_q <= '0; trig_q <= 1'b0; pdu_len_q <= '0;
      pck_ident_q <= '0; pck_idx_q <= '0; pdu_chan_q <= '0; byte_q <= '0;
    end else begin
      wr_addr_q <= wr_addr_d; wr_size_q <= wr_size_d; storing_q <= storing_d; start_q <= start_d;
      chan_q <= chan_d; ident_q <= ident_d; idx_q <= idx_d; wr_idx_q <= wr_idx_d; rd_idx_q <= rd_idx_d;
      level_q <= level_d; rd_addr_q <= rd_addr_d; trig_q <= trig_d; pdu_len_q <= pdu_len_d;
      pck_ident_q <= pck_ident_d; pck_idx_q <= pck_idx_d; pdu_chan_q <= pdu_chan_d; byte_q <= byte_d;
    end
  end

  assign bus.o_full      = full;
  assign bus.o_empty     = (level_q == '0);
  assign bus.o_level     = level_q;
  assign bus.o_trig_send = trig_q;
  assign bus.o_pdu_len   = pdu_len_q;
  assign bus.o_pck_ident = pck_ident_q;
  assign bus.o_pck_idx   = pck_idx_q;
  assign bus.o_pdu_chan  = pdu_chan_q;
  assign bus.o_byte      = byte_q;

`ifdef EPQ_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.i_wr && bus.i_din && full) drop_cnt_d = sat_inc16(drop_cnt_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign bus.o_drop_cnt = drop_cnt_q;
`else
  assign bus.o_drop_cnt = '0;
`endif
endmodule
